mig_frame_reader: RTL and testbench
===================================

Name: mig_frame_reader

Overview:
- Read-side master for the DDR frame buffer.
- Issues sequential 128-bit read commands to the MIG user interface and captures the returned phrases in a small credit-protected FIFO.
- Presents the phrases on a 128-bit valid/ready stream with a frame-start tag.
- Sits between the MIG and the phrase-to-byte unpacker. It is the counterpart of the write path that packs bytes into phrases and stores them.

Parameters:
- FRAME_PHRASES, 3600, phrases per frame; the read address wraps after this many.
- ADDR_BASE, 0, MIG address of phrase 0 of the frame.
- ADDR_STRIDE, 8, MIG address increment per phrase.
- ADDR_WIDTH, 27, width of app_addr.
- DEPTH, 8, return FIFO entries; also the maximum of in-flight reads plus buffered phrases. Must be a power of two, at least 2.

Ports:
- clk_in  input  1  system/MIG UI clock
- rst_in  input  1  asynchronous, active-high reset
- enable_in  input  1  permit new read commands
- app_addr  output  ADDR_WIDTH  MIG command address
- app_cmd  output  3  MIG command, constant 3'b001 (read)
- app_en  output  1  MIG command valid
- app_rdy  input  1  MIG command accept
- app_rd_data  input  128  MIG read data
- app_rd_data_valid  input  1  MIG read data strobe; cannot be backpressured
- valid_phrase  output  1  output phrase valid
- ready_phrase  input  1  downstream accept
- phrase_data  output  128  output phrase
- phrase_tuser  output  1  high on the phrase that is phrase 0 of a frame
- frame_done_out  output  1  one-cycle pulse when the last phrase of a frame is accepted downstream
- overflow_err  output  1  sticky: read data arrived while the FIFO was full

Behaviour:
- Reset (asynchronous, any time):
  - Clears the command address index, the return index, the in-flight count and the FIFO pointers; clears overflow_err; state returns to IDLE.
  - Outputs during reset: app_en=0, app_addr=ADDR_BASE, valid_phrase=0, phrase_tuser=0, frame_done_out=0, overflow_err=0.
  - The MIG is reset alongside this block. Reads still in flight at reset are not tracked.
- Credit rule:
  - credits_used = in_flight + fifo_count, and it never exceeds DEPTH.
  - A command may be presented only when credits_used < DEPTH.
  - A command handshake (app_en && app_rdy) increments in_flight.
  - An app_rd_data_valid beat decrements in_flight and increments fifo_count.
  - A downstream handshake (valid_phrase && ready_phrase) decrements fifo_count.
  - Simultaneous events combine arithmetically in the same cycle.
- Command state machine:
  - IDLE -> REQ when enable_in=1 and credits_used < DEPTH.
  - REQ: app_en=1 and app_addr = ADDR_BASE + cmd_idx*ADDR_STRIDE, both held stable until app_rdy.
  - On handshake in REQ:
    - cmd_idx advances, wrapping FRAME_PHRASES-1 -> 0.
    - Stay in REQ if enable_in=1 and credits_used after the update < DEPTH; otherwise go to IDLE.
  - Deasserting enable_in while in REQ does not drop app_en; the pending command completes first.
  - Peak throughput is one command per cycle while app_rdy=1 and credits allow.
- Return path:
  - MIG returns data in order. Each beat is written to the FIFO with tag tuser = (ret_idx == 0).
  - ret_idx wraps FRAME_PHRASES-1 -> 0.
  - If a beat arrives with fifo_count == DEPTH, the beat is dropped and overflow_err sets. This cannot happen when the credit rule holds.
- Output stream:
  - valid_phrase = (fifo_count != 0).
  - phrase_data and phrase_tuser show the FIFO head and are stable while valid_phrase=1 and ready_phrase=0.
  - Latency from app_rd_data_valid to valid_phrase is one cycle, through the registered FIFO write.
  - Writing into an empty FIFO and popping it in the same cycle is not allowed; the write lands and the pop waits one cycle.
  - Writing into a full FIFO in the same cycle as a pop is allowed: the pop frees the slot and no overflow is flagged.
- frame_done_out is registered and pulses on the cycle after a downstream handshake whose tag was the last phrase of a frame. That phrase is tracked by an output index reaching FRAME_PHRASES-1.
- Address arithmetic is modulo 2^ADDR_WIDTH. cmd_idx, ret_idx and the output index use $clog2(FRAME_PHRASES) bits.

Test Plan:
1. Steady stream: reset, enable_in=1, app_rdy=1, MIG model returns data 4 cycles after command, ready_phrase=1.
   - Addresses are 0, 8, 16, …
   - Phrases arrive in order. phrase_tuser=1 only on the first phrase and on phrase 3600.
   - frame_done_out pulses once per 3600 phrases.
2. Backpressure: ready_phrase=0 throughout.
   - Exactly DEPTH=8 commands are issued, then app_en=0.
   - 8 phrases are buffered; phrase_data is stable; overflow_err stays 0.
   - Raising ready_phrase drains 8 phrases and issuing resumes.
3. app_rdy stalls: hold app_rdy=0 for 5 cycles mid-frame.
   - app_en and app_addr are held stable.
   - Exactly one command counts when app_rdy rises.
4. Frame wrap with FRAME_PHRASES=4 and ADDR_BASE=0x100.
   - Addresses are 0x100, 0x108, 0x110, 0x118, then 0x100.
   - tuser is set on phrases 0 and 4. frame_done_out follows the 4th and 8th accepted phrase.
5. Disable mid-request: drop enable_in while app_en=1 and app_rdy=0.
   - The command completes on app_rdy and no further commands are issued.
   - In-flight data still drains to the output.
6. Async reset mid-stream: assert rst_in between clock edges with 3 reads in flight.
   - All outputs go to reset values immediately.
   - After release with enable_in=1, the first command address is ADDR_BASE and the first output phrase has tuser=1.

Source files
------------

// File: rtl/mig_frame_reader.sv
// Read-side MIG master: streams sequential phrase reads out of the frame buffer
// and hands them downstream through a credit-protected return FIFO.
module mig_frame_reader #(
   parameter int unsigned FRAME_PHRASES = 3600,
   parameter int unsigned ADDR_BASE     = 0,
   parameter int unsigned ADDR_STRIDE   = 8,
   parameter int unsigned ADDR_WIDTH    = 27,
   parameter int unsigned DEPTH         = 8
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  enable_in,
   output logic [ADDR_WIDTH-1:0] app_addr,
   output logic [2:0]            app_cmd,
   output logic                  app_en,
   input  logic                  app_rdy,
   input  logic [127:0]          app_rd_data,
   input  logic                  app_rd_data_valid,
   output logic                  valid_phrase,
   input  logic                  ready_phrase,
   output logic [127:0]          phrase_data,
   output logic                  phrase_tuser,
   output logic                  frame_done_out,
   output logic                  overflow_err
);

   localparam int unsigned IDX_W  = (FRAME_PHRASES > 1) ? $clog2(FRAME_PHRASES) : 1;
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned CRED_W = CNT_W + 1;

   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(FRAME_PHRASES - 1);
   localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CRED_W-1:0]     CRED_MAX = CRED_W'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] A_BASE   = ADDR_WIDTH'(ADDR_BASE);
   localparam logic [ADDR_WIDTH-1:0] A_STRIDE = ADDR_WIDTH'(ADDR_STRIDE);

   typedef enum logic {IDLE, REQ} state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      cmd_idx_q, cmd_idx_d;
   logic [IDX_W-1:0]      ret_idx_q, ret_idx_d;
   logic [IDX_W-1:0]      out_idx_q, out_idx_d;
   logic [CNT_W-1:0]      in_flight_q, in_flight_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  valid_q, valid_d;
   logic                  frame_done_q, frame_done_d;
   logic                  ovf_q, ovf_d;

   logic [128:0]          fifo_mem [DEPTH];
   logic                  cmd_hs, pop, push, ret_dec;
   logic [CRED_W-1:0]     credits_now, credits_next;

   // Credit accounting, FIFO bookkeeping and command sequencing
   always_comb begin
      state_d      = state_q;
      cmd_idx_d    = cmd_idx_q;
      ret_idx_d    = ret_idx_q;
      out_idx_d    = out_idx_q;
      in_flight_d  = in_flight_q;
      count_d      = count_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      ovf_d        = ovf_q;

      cmd_hs  = (state_q == REQ) && app_rdy;
      pop     = valid_q && ready_phrase;
      push    = app_rd_data_valid && ((count_q != CNT_FULL) || pop);
      // Beats for reads issued before a reset are untracked; never underflow
      ret_dec = app_rd_data_valid && (in_flight_q != '0);

      if (cmd_hs && !ret_dec)      in_flight_d = in_flight_q + CNT_W'(1);
      else if (!cmd_hs && ret_dec) in_flight_d = in_flight_q - CNT_W'(1);

      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      if (app_rd_data_valid)
         ret_idx_d = (ret_idx_q == IDX_LAST) ? '0 : ret_idx_q + IDX_W'(1);
      if (pop)
         out_idx_d = (out_idx_q == IDX_LAST) ? '0 : out_idx_q + IDX_W'(1);

      if (app_rd_data_valid && !push) ovf_d = 1'b1;
      frame_done_d = pop && (out_idx_q == IDX_LAST);
      valid_d      = (count_d != '0);

      credits_now  = CRED_W'(in_flight_q) + CRED_W'(count_q);
      credits_next = CRED_W'(in_flight_d) + CRED_W'(count_d);

      case (state_q)
         IDLE: if (enable_in && (credits_now < CRED_MAX)) state_d = REQ;
         REQ: begin
            if (app_rdy) begin
               cmd_idx_d = (cmd_idx_q == IDX_LAST) ? '0 : cmd_idx_q + IDX_W'(1);
               if (!(enable_in && (credits_next < CRED_MAX))) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      addr_d = A_BASE + ADDR_WIDTH'(cmd_idx_d) * A_STRIDE;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         cmd_idx_q    <= '0;
         ret_idx_q    <= '0;
         out_idx_q    <= '0;
         in_flight_q  <= '0;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         addr_q       <= A_BASE;
         valid_q      <= 1'b0;
         frame_done_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_idx_q    <= cmd_idx_d;
         ret_idx_q    <= ret_idx_d;
         out_idx_q    <= out_idx_d;
         in_flight_q  <= in_flight_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         addr_q       <= addr_d;
         valid_q      <= valid_d;
         frame_done_q <= frame_done_d;
         ovf_q        <= ovf_d;
      end
   end

   // Return storage: {frame-start tag, phrase}
   always_ff @(posedge clk_in) begin
      if (push) fifo_mem[wr_ptr_q] <= {(ret_idx_q == '0), app_rd_data};
   end

   assign app_cmd        = 3'b001;
   assign app_en         = (state_q == REQ);
   assign app_addr       = addr_q;
   assign valid_phrase   = valid_q;
   assign phrase_data    = fifo_mem[rd_ptr_q][127:0];
   assign phrase_tuser   = valid_q && fifo_mem[rd_ptr_q][128];
   assign frame_done_out = frame_done_q;
   assign overflow_err   = ovf_q;

endmodule

// File: tb/tb_mig_frame_reader.sv
// Directed bench for mig_frame_reader: a full-size instance and a 4-phrase-frame
// instance, each fed by a fixed-latency MIG read model.
module tb_mig_frame_reader;

   localparam int unsigned AW = 27;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic          a_en, a_app_en, a_rdy, a_rdv, a_vld, a_ready, a_tuser, a_fd, a_ovf;
   logic [AW-1:0] a_addr;
   logic [2:0]    a_cmd;
   logic [127:0]  a_rdata, a_pdata;
   logic          b_en, b_app_en, b_rdy, b_rdv, b_vld, b_ready, b_tuser, b_fd, b_ovf;
   logic [AW-1:0] b_addr;
   logic [2:0]    b_cmd;
   logic [127:0]  b_rdata, b_pdata;

   int vectors = 0;
   int miscompares = 0;

   function automatic logic [127:0] mk(input logic [AW-1:0] a);
      logic [31:0] w;
      w = 32'(a);
      return {w ^ 32'hDEAD_BEEF, ~w, w + 32'd1, w};
   endfunction

   mig_frame_reader u_a (
      .clk_in(clk), .rst_in(rst), .enable_in(a_en),
      .app_addr(a_addr), .app_cmd(a_cmd), .app_en(a_app_en), .app_rdy(a_rdy),
      .app_rd_data(a_rdata), .app_rd_data_valid(a_rdv),
      .valid_phrase(a_vld), .ready_phrase(a_ready), .phrase_data(a_pdata),
      .phrase_tuser(a_tuser), .frame_done_out(a_fd), .overflow_err(a_ovf));

   mig_frame_reader #(.FRAME_PHRASES(4), .ADDR_BASE(32'h100)) u_b (
      .clk_in(clk), .rst_in(rst), .enable_in(b_en),
      .app_addr(b_addr), .app_cmd(b_cmd), .app_en(b_app_en), .app_rdy(b_rdy),
      .app_rd_data(b_rdata), .app_rd_data_valid(b_rdv),
      .valid_phrase(b_vld), .ready_phrase(b_ready), .phrase_data(b_pdata),
      .phrase_tuser(b_tuser), .frame_done_out(b_fd), .overflow_err(b_ovf));

   // MIG models: data returns 4 cycles after the command handshake
   logic [3:0]    a_vp, b_vp;
   logic [AW-1:0] a_ap [4];
   logic [AW-1:0] b_ap [4];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         a_vp <= '0;
         b_vp <= '0;
      end else begin
         a_vp <= {a_vp[2:0], a_app_en && a_rdy};
         b_vp <= {b_vp[2:0], b_app_en && b_rdy};
      end
   end
   always @(posedge clk) begin
      a_ap[0] <= a_addr;
      b_ap[0] <= b_addr;
      for (int i = 1; i < 4; i++) begin
         a_ap[i] <= a_ap[i-1];
         b_ap[i] <= b_ap[i-1];
      end
   end
   assign a_rdv   = a_vp[3];
   assign a_rdata = mk(a_ap[3]);
   assign b_rdv   = b_vp[3];
   assign b_rdata = mk(b_ap[3]);

   // Instance A observer: command addresses, phrase order/tags, frame_done timing
   int a_cmds, a_pops, a_tus, a_fds, a_err;
   logic a_fd_exp;
   always @(posedge clk) begin
      if (rst) begin
         a_cmds = 0; a_pops = 0; a_tus = 0; a_fds = 0; a_err = 0; a_fd_exp = 1'b0;
      end else begin
         if (a_fd !== a_fd_exp) a_err++;
         a_fd_exp = 1'b0;
         if (a_fd === 1'b1) a_fds++;
         if (a_app_en && a_rdy) begin
            if (a_addr !== AW'((a_cmds % 3600) * 8)) a_err++;
            a_cmds++;
         end
         if (a_vld && a_ready) begin
            if (a_pdata !== mk(AW'((a_pops % 3600) * 8))) a_err++;
            if (a_tuser !== ((a_pops % 3600) == 0)) a_err++;
            if (a_tuser === 1'b1) a_tus++;
            if ((a_pops % 3600) == 3599) a_fd_exp = 1'b1;
            a_pops++;
         end
      end
   end

   // Instance B recorder
   int b_cmds, b_pops, b_fds;
   logic [AW-1:0] b_addr_log [8];
   logic [7:0]    b_tu_log;
   int            b_fd_at [2];
   always @(posedge clk) begin
      if (rst) begin
         b_cmds = 0; b_pops = 0; b_fds = 0; b_tu_log = '0;
      end else begin
         if (b_fd === 1'b1) begin
            if (b_fds < 2) b_fd_at[b_fds] = b_pops;
            b_fds++;
         end
         if (b_app_en && b_rdy) begin
            if (b_cmds < 8) b_addr_log[b_cmds] = b_addr;
            b_cmds++;
         end
         if (b_vld && b_ready) begin
            if (b_pops < 8) b_tu_log[b_pops] = b_tuser;
            b_pops++;
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_app_en"}, 128'(a_app_en), 128'(0));
      chk({pfx, "_app_addr"}, 128'(a_addr), 128'(0));
      chk({pfx, "_valid"}, 128'(a_vld), 128'(0));
      chk({pfx, "_tuser"}, 128'(a_tuser), 128'(0));
      chk({pfx, "_frame_done"}, 128'(a_fd), 128'(0));
      chk({pfx, "_overflow"}, 128'(a_ovf), 128'(0));
   endtask

   initial begin
      bit done;
      int c0;
      rst = 1'b1;
      a_en = 0; a_rdy = 0; a_ready = 0;
      b_en = 0; b_rdy = 0; b_ready = 0;
      repeat (2) tick();
      chk_reset_outputs("rst");
      chk("rst_app_cmd", 128'(a_cmd), 128'(3'b001));
      chk("rst_b_app_addr", 128'(b_addr), 128'(27'h100));
      rst = 1'b0;

      // Frame wrap on the 4-phrase instance
      b_en = 1; b_rdy = 1; b_ready = 1;
      done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         tick();
         done = (b_pops >= 8) && (b_fds >= 2);
      end
      b_en = 0;
      chk("wrap_done", 128'(done), 128'(1));
      chk("wrap_addr0", 128'(b_addr_log[0]), 128'(27'h100));
      chk("wrap_addr1", 128'(b_addr_log[1]), 128'(27'h108));
      chk("wrap_addr2", 128'(b_addr_log[2]), 128'(27'h110));
      chk("wrap_addr3", 128'(b_addr_log[3]), 128'(27'h118));
      chk("wrap_addr4", 128'(b_addr_log[4]), 128'(27'h100));
      chk("wrap_tuser", 128'(b_tu_log), 128'(8'h11));
      chk("wrap_fd_first", 128'(b_fd_at[0]), 128'(4));
      chk("wrap_fd_second", 128'(b_fd_at[1]), 128'(8));
      chk("wrap_overflow", 128'(b_ovf), 128'(0));

      // Backpressure: credits cap outstanding work at 8
      a_en = 1; a_rdy = 1; a_ready = 0;
      repeat (20) tick();
      chk("bp_cmds", 128'(a_cmds), 128'(8));
      chk("bp_app_en", 128'(a_app_en), 128'(0));
      chk("bp_valid", 128'(a_vld), 128'(1));
      chk("bp_tuser", 128'(a_tuser), 128'(1));
      chk("bp_data", a_pdata, mk(27'd0));
      repeat (3) tick();
      chk("bp_data_held", a_pdata, mk(27'd0));
      chk("bp_cmds_held", 128'(a_cmds), 128'(8));
      chk("bp_overflow", 128'(a_ovf), 128'(0));

      // Release and stream past one full frame
      a_ready = 1;
      done = 0;
      for (int i = 0; i < 5000 && !done; i++) begin
         tick();
         done = (a_pops >= 3602);
      end
      chk("stream_done", 128'(done), 128'(1));
      chk("stream_frame_done", 128'(a_fds), 128'(1));
      chk("stream_tuser_count", 128'(a_tus), 128'(2));
      chk("stream_errors", 128'(a_err), 128'(0));
      chk("stream_overflow", 128'(a_ovf), 128'(0));

      // app_rdy stall: command held, counted once
      a_rdy = 0;
      tick();
      c0 = a_cmds;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_app_en", 128'(a_app_en), 128'(1));
         chk("stall_app_addr", 128'(a_addr), 128'(AW'((c0 % 3600) * 8)));
      end
      chk("stall_no_cmd", 128'(a_cmds), 128'(c0));
      a_rdy = 1;
      tick();
      chk("stall_one_cmd", 128'(a_cmds), 128'(c0 + 1));

      // Disable while a command is pending
      a_rdy = 0;
      repeat (2) tick();
      a_en = 0;
      tick();
      chk("dis_app_en_held", 128'(a_app_en), 128'(1));
      c0 = a_cmds;
      a_rdy = 1;
      tick();
      chk("dis_completes", 128'(a_cmds), 128'(c0 + 1));
      chk("dis_app_en_low", 128'(a_app_en), 128'(0));
      repeat (15) tick();
      chk("dis_no_more_cmds", 128'(a_cmds), 128'(c0 + 1));
      chk("dis_drained", 128'(a_vld), 128'(0));
      chk("dis_pops_match", 128'(a_pops), 128'(a_cmds));
      chk("dis_errors", 128'(a_err), 128'(0));

      // Async reset with three reads in flight
      a_rdy = 0; a_en = 1;
      tick();
      chk("ar_app_en", 128'(a_app_en), 128'(1));
      a_rdy = 1;
      repeat (3) tick();
      a_rdy = 0;
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs("ar");
      tick();
      rst = 1'b0;
      a_rdy = 1;
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         tick();
         done = a_app_en;
      end
      chk("ar_cmd_seen", 128'(done), 128'(1));
      chk("ar_first_addr", 128'(a_addr), 128'(0));
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         tick();
         done = a_vld;
      end
      chk("ar_valid_seen", 128'(done), 128'(1));
      chk("ar_first_tuser", 128'(a_tuser), 128'(1));
      chk("ar_first_data", a_pdata, mk(27'd0));
      repeat (20) tick();
      chk("ar_errors", 128'(a_err), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
